// File: rtl/lsu_mem_if.sv
// lsu_mem_if: bundles the three handshakes of the memory-access stage.
//   ex_*   execute -> lsu instruction handoff (valid/ready)
//   mem_*  lsu -> data bus request (req/gnt) and response (rvalid/rdata)
//   wb_*   lsu -> writeback result (valid/ready)
// Signal suffixes are relative to the lsu: _i is driven into it, _o out of it.
// modport slave  : the lsu_mem stage itself
// modport master : the environment around it (execute stage, bus, writeback)
interface lsu_mem_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // execute side
  logic                      ex_valid_i;
  logic                      ex_ready_o;
  logic [DATA_WIDTH-1:0]     ex_alu_ans_i;
  logic [DATA_WIDTH-1:0]     ex_rs2_val_i;
  logic [2:0]                ex_func3_i;
  logic                      ex_is_load_i;
  logic                      ex_is_store_i;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_i;
  logic                      ex_wb_en_i;
  // data bus side
  logic                      mem_req_o;
  logic                      mem_gnt_i;
  logic                      mem_we_o;
  logic [ADDR_WIDTH-1:0]     mem_addr_o;
  logic [DATA_WIDTH-1:0]     mem_wdata_o;
  logic [3:0]                mem_wstrb_o;
  logic                      mem_rvalid_i;
  logic [DATA_WIDTH-1:0]     mem_rdata_i;
  // writeback side
  logic                      wb_valid_o;
  logic                      wb_ready_i;
  logic                      wb_en_o;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_o;
  logic [DATA_WIDTH-1:0]     wb_val_o;
  logic                      wb_misalign_o;

  modport slave (
    input  ex_valid_i, ex_alu_ans_i, ex_rs2_val_i, ex_func3_i, ex_is_load_i,
           ex_is_store_i, ex_rd_i, ex_wb_en_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i, wb_ready_i,
    output ex_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
           wb_valid_o, wb_en_o, wb_rd_o, wb_val_o, wb_misalign_o
  );

  modport master (
    output ex_valid_i, ex_alu_ans_i, ex_rs2_val_i, ex_func3_i, ex_is_load_i,
           ex_is_store_i, ex_rd_i, ex_wb_en_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i, wb_ready_i,
    input  ex_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
           wb_valid_o, wb_en_o, wb_rd_o, wb_val_o, wb_misalign_o
  );
endinterface

// File: rtl/lsu_mem.sv
// lsu_mem: memory-access pipeline stage.
// Accepts one instruction at a time from execute. Loads/stores (B/H/W, signed
// and unsigned loads) go out over a req/gnt request with a single rvalid
// response; the result is handed to writeback as one registered slot that
// holds until wb_ready_i. Non-memory instructions and misaligned accesses skip
// the bus and produce their writeback result one cycle after acceptance.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  lsu_mem_if.slave (ex_*, mem_*, wb_* handshakes)
module lsu_mem #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic       clk,
  input logic       rst,
  lsu_mem_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    state_reg;

  // registered outputs
  logic                      mem_req_reg;
  logic                      mem_we_reg;
  logic [ADDR_WIDTH-1:0]     mem_addr_reg;
  logic [DATA_WIDTH-1:0]     mem_wdata_reg;
  logic [3:0]                mem_wstrb_reg;
  logic                      wb_valid_reg;
  logic                      wb_en_reg;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_reg;
  logic [DATA_WIDTH-1:0]     wb_val_reg;
  logic                      wb_misalign_reg;

  // operation latched at acceptance, needed when the response returns
  logic                      op_load_reg;
  logic [2:0]                op_func3_reg;
  logic [1:0]                op_off_reg;
  logic                      op_wb_en_reg;
  logic [REG_ADDR_WIDTH-1:0] op_rd_reg;

  // ---------------------------------------------------------------------------
  // Acceptance and decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic ex_ready;
  logic ex_fire;
  logic ex_is_mem;
  logic size_byte;
  logic size_half;
  logic [1:0] ex_off;
  logic ex_misalign;
  logic rd_nonzero;

  // A new instruction may only enter when the writeback slot is free or is
  // being drained this cycle, so the slot is always empty when a bus response
  // later needs it.
  assign ex_ready    = (state_reg == IDLE) && (!wb_valid_reg || bus.wb_ready_i);
  assign ex_fire     = bus.ex_valid_i && ex_ready;
  assign ex_is_mem   = bus.ex_is_load_i || bus.ex_is_store_i;
  // func3[1:0]: 00 byte, 01 half, anything else (incl. 011/110/111) word
  assign size_byte   = (bus.ex_func3_i[1:0] == 2'b00);
  assign size_half   = (bus.ex_func3_i[1:0] == 2'b01);
  assign ex_off      = bus.ex_alu_ans_i[1:0];
  assign ex_misalign = (size_half && ex_off[0]) ||
                       (!size_byte && !size_half && (ex_off != 2'b00));
  assign rd_nonzero  = (bus.ex_rd_i != '0);

  // ---------------------------------------------------------------------------
  // Store byte lanes: strobe and data per lane
  // ---------------------------------------------------------------------------
  logic [3:0]            lane_strb;
  logic [DATA_WIDTH-1:0] lane_wdata;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      // byte: only the addressed lane; half: the addressed pair; word: all
      assign lane_strb[gi] = size_byte ? (ex_off == LANE) :
                             size_half ? (ex_off[1] == LANE[1]) : 1'b1;
      // byte data is replicated to every lane, half data to both halves
      assign lane_wdata[8*gi +: 8] = size_byte ? bus.ex_rs2_val_i[7:0] :
                                     size_half ? bus.ex_rs2_val_i[8*(gi%2) +: 8] :
                                                 bus.ex_rs2_val_i[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Load data extraction from the returned word
  // ---------------------------------------------------------------------------
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_val;

  always_comb begin
    ld_byte = bus.mem_rdata_i[{op_off_reg, 3'b000} +: 8];
    ld_half = op_off_reg[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
    case (op_func3_reg)
      3'b000:  ld_val = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b001:  ld_val = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  ld_val = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_val = bus.mem_rdata_i;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      mem_wstrb_reg   <= '0;
      wb_valid_reg    <= 1'b0;
      wb_en_reg       <= 1'b0;
      wb_rd_reg       <= '0;
      wb_val_reg      <= '0;
      wb_misalign_reg <= 1'b0;
      op_load_reg     <= 1'b0;
      op_func3_reg    <= '0;
      op_off_reg      <= '0;
      op_wb_en_reg    <= 1'b0;
      op_rd_reg       <= '0;
    end else begin
      // drain the slot; a result loaded below in the same cycle overrides this
      if (wb_valid_reg && bus.wb_ready_i) begin
        wb_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (ex_fire) begin
            if (!ex_is_mem || ex_misalign) begin
              // result straight to writeback, no bus traffic
              wb_valid_reg    <= 1'b1;
              wb_val_reg      <= bus.ex_alu_ans_i;
              wb_rd_reg       <= bus.ex_rd_i;
              wb_en_reg       <= !ex_is_mem && bus.ex_wb_en_i && rd_nonzero;
              wb_misalign_reg <= ex_is_mem;
            end else begin
              op_load_reg   <= bus.ex_is_load_i;
              op_func3_reg  <= bus.ex_func3_i;
              op_off_reg    <= ex_off;
              op_wb_en_reg  <= bus.ex_wb_en_i && rd_nonzero;
              op_rd_reg     <= bus.ex_rd_i;
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= bus.ex_is_store_i;
              mem_addr_reg  <= {bus.ex_alu_ans_i[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata_reg <= bus.ex_is_store_i ? lane_wdata : '0;
              mem_wstrb_reg <= lane_strb;
              state_reg     <= REQ;
            end
          end
        end

        REQ: begin
          // request fields stay frozen until granted
          if (bus.mem_gnt_i) begin
            mem_req_reg <= 1'b0;
            state_reg   <= RESP;
          end
        end

        RESP: begin
          if (bus.mem_rvalid_i) begin
            wb_valid_reg    <= 1'b1;
            wb_misalign_reg <= 1'b0;
            wb_rd_reg       <= op_rd_reg;
            wb_en_reg       <= op_load_reg && op_wb_en_reg;
            wb_val_reg      <= op_load_reg ? ld_val : '0;
            state_reg       <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ex_ready_o    = ex_ready;
  assign bus.mem_req_o     = mem_req_reg;
  assign bus.mem_we_o      = mem_we_reg;
  assign bus.mem_addr_o    = mem_addr_reg;
  assign bus.mem_wdata_o   = mem_wdata_reg;
  assign bus.mem_wstrb_o   = mem_wstrb_reg;
  assign bus.wb_valid_o    = wb_valid_reg;
  assign bus.wb_en_o       = wb_en_reg;
  assign bus.wb_rd_o       = wb_rd_reg;
  assign bus.wb_val_o      = wb_val_reg;
  assign bus.wb_misalign_o = wb_misalign_reg;

endmodule
